// File: rtl/pll_lock_supervisor_pkg.sv
// pll_sup_pkg: supervisor state encoding and counter-width helper
package pll_sup_pkg;
  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } sup_state_e;
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: PLL control, lock status and channel reset bundle
interface pll_lock_supervisor_if #(
  parameter int N_CHANNELS = 2,
  parameter int CNT_W      = 8
);
  logic                  pll_locked;
  logic                  sw_restart;
  logic                  pll_resetb;
  logic [N_CHANNELS-1:0] chan_rst;
  logic                  ready;
  logic                  timeout_err;
  logic [CNT_W-1:0]      loss_count;
  logic [CNT_W-1:0]      retry_count;
  modport slave (
    input  pll_locked, sw_restart,
    output pll_resetb, chan_rst, ready, timeout_err, loss_count, retry_count
  );
  modport master (
    output pll_locked, sw_restart,
    input  pll_resetb, chan_rst, ready, timeout_err, loss_count, retry_count
  );
endinterface

// File: rtl/pll_lock_supervisor_sync_1bit.sv
// sync_1bit: multi-flop synchroniser for a single asynchronous level
module sync_1bit #(
  parameter int N_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [N_STAGES-1:0] sync_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[N_STAGES-2:0], d_i};
  assign q_o = sync_q[N_STAGES-1];
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset/lock qualification with staggered channel reset release
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int N_CHANNELS          = 2,
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGGER_CYCLES      = 16,
  parameter int CNT_W               = 8
) (
  input logic                  clk,
  input logic                  rst,
  pll_lock_supervisor_if.slave io
);
  localparam int RST_W = cnt_width(PLL_RESET_CYCLES - 1);
  localparam int STB_W = cnt_width(LOCK_STABLE_CYCLES - 1);
  localparam int TO_W  = cnt_width(LOCK_TIMEOUT_CYCLES - 1);
  localparam int REL_W = cnt_width(N_CHANNELS * STAGGER_CYCLES - 1);
  if (N_CHANNELS < 1 || SYNC_STAGES < 2 || PLL_RESET_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 ||
      LOCK_TIMEOUT_CYCLES <= LOCK_STABLE_CYCLES || STAGGER_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("pll_lock_supervisor: parameter out of range");
  end
  sup_state_e            state_q, state_d;
  logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [STB_W-1:0]      stable_cnt_q, stable_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [REL_W-1:0]      rel_cnt_q, rel_cnt_d;
  logic                  pll_resetb_q, pll_resetb_d;
  logic [N_CHANNELS-1:0] chan_rst_q, chan_rst_d;
  logic                  ready_q, ready_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]      loss_q, loss_d;
  logic [CNT_W-1:0]      retry_q, retry_d;
  logic                  lock_s;
  logic                  restart;
  sync_1bit #(.N_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (io.pll_locked),
    .q_o (lock_s)
  );
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    stable_cnt_d  = stable_cnt_q;
    to_cnt_d      = to_cnt_q;
    rel_cnt_d     = rel_cnt_q;
    pll_resetb_d  = pll_resetb_q;
    chan_rst_d    = chan_rst_q;
    ready_d       = ready_q;
    timeout_err_d = timeout_err_q;
    loss_d        = loss_q;
    retry_d       = retry_q;
    restart       = 1'b0;
    case (state_q)
      PLL_RST:
        if (int'(rst_cnt_q) == PLL_RESET_CYCLES - 1) begin
          state_d      = WAIT_LOCK;
          pll_resetb_d = 1'b1;
          stable_cnt_d = '0;
          to_cnt_d     = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      WAIT_LOCK:
        if (lock_s && int'(stable_cnt_q) == LOCK_STABLE_CYCLES - 1) begin
          state_d   = RELEASE;
          rel_cnt_d = '0;
        end else if (int'(to_cnt_q) == LOCK_TIMEOUT_CYCLES - 1) begin
          restart       = 1'b1;
          timeout_err_d = 1'b1;
          retry_d       = retry_q + CNT_W'(~&retry_q);
        end else begin
          to_cnt_d     = to_cnt_q + 1'b1;
          stable_cnt_d = lock_s ? stable_cnt_q + 1'b1 : '0;
        end
      RELEASE:
        if (!lock_s) begin
          restart = 1'b1;
          loss_d  = loss_q + CNT_W'(~&loss_q);
        end else begin
          rel_cnt_d = rel_cnt_q + 1'b1;
          // a channel drops out of reset one cycle ahead of its slot so the registered output lands on it
          for (int i = 0; i < N_CHANNELS; i++)
            chan_rst_d[i] = chan_rst_q[i] & (int'(rel_cnt_q) != (i + 1) * STAGGER_CYCLES - 1);
          if (int'(rel_cnt_q) == N_CHANNELS * STAGGER_CYCLES - 1) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end
      RUN:
        if (!lock_s) begin
          restart = 1'b1;
          loss_d  = loss_q + CNT_W'(~&loss_q);
        end
      default: state_d = PLL_RST;
    endcase
    if (restart || io.sw_restart) begin
      state_d      = PLL_RST;
      rst_cnt_d    = '0;
      pll_resetb_d = 1'b0;
      chan_rst_d   = '1;
      ready_d      = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q       <= PLL_RST;
      rst_cnt_q     <= '0;
      stable_cnt_q  <= '0;
      to_cnt_q      <= '0;
      rel_cnt_q     <= '0;
      pll_resetb_q  <= 1'b0;
      chan_rst_q    <= '1;
      ready_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      loss_q        <= '0;
      retry_q       <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      stable_cnt_q  <= stable_cnt_d;
      to_cnt_q      <= to_cnt_d;
      rel_cnt_q     <= rel_cnt_d;
      pll_resetb_q  <= pll_resetb_d;
      chan_rst_q    <= chan_rst_d;
      ready_q       <= ready_d;
      timeout_err_q <= timeout_err_d;
      loss_q        <= loss_d;
      retry_q       <= retry_d;
    end
  assign io.pll_resetb  = pll_resetb_q;
  assign io.chan_rst    = chan_rst_q;
  assign io.ready       = ready_q;
  assign io.timeout_err = timeout_err_q;
  assign io.loss_count  = loss_q;
  assign io.retry_count = retry_q;
endmodule
